// File: rtl/mips_prog_encoder.sv
// Program encoder: turns instruction descriptors into 32-bit MIPS words and
// streams them into instruction memory, tracking word count and XOR checksum.
module mips_prog_encoder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned DEPTH     = 256
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [2:0]        s_kind,
    input  logic [4:0]        s_rs,
    input  logic [4:0]        s_rt,
    input  logic [4:0]        s_rd,
    input  logic [5:0]        s_funct,
    input  logic [15:0]       s_imm,
    input  logic [25:0]       s_target,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count,
    output logic [31:0]       checksum
);

    typedef enum logic [2:0] {StIdle, StRun, StWrite, StDone, StErr} state_e;

    localparam logic [2:0] KindR    = 3'd0;
    localparam logic [2:0] KindLw   = 3'd1;
    localparam logic [2:0] KindSw   = 3'd2;
    localparam logic [2:0] KindBeq  = 3'd3;
    localparam logic [2:0] KindAddi = 3'd4;
    localparam logic [2:0] KindAndi = 3'd5;
    localparam logic [2:0] KindJ    = 3'd6;
    localparam logic [2:0] KindEnd  = 3'd7;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DepthW   = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [31:0]         csum_q, csum_d;
    logic [31:0]         enc_word;

    // Assemble the instruction word for the current descriptor (shamt is always 0).
    always_comb begin
        enc_word = 32'h0;
        unique case (s_kind)
            KindR:    enc_word = {6'b000000, s_rs, s_rt, s_rd, 5'b00000, s_funct};
            KindLw:   enc_word = {6'b100011, s_rs, s_rt, s_imm};
            KindSw:   enc_word = {6'b101011, s_rs, s_rt, s_imm};
            KindBeq:  enc_word = {6'b000100, s_rs, s_rt, s_imm};
            KindAddi: enc_word = {6'b001000, s_rs, s_rt, s_imm};
            KindAndi: enc_word = {6'b001100, s_rs, s_rt, s_imm};
            KindJ:    enc_word = {6'b000010, s_target};
            default:  enc_word = 32'h0;
        endcase
    end

    // Next-state logic for the load sequencer and its counters.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        csum_d  = csum_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StRun;
                    addr_d  = BaseAddr;
                    count_d = '0;
                    csum_d  = '0;
                end
            end
            StRun: begin
                if (s_valid) begin
                    if (s_kind == KindEnd) begin
                        state_d = StDone;
                    end else if (count_q == DepthW) begin
                        state_d = StErr;
                    end else begin
                        wdata_d = enc_word;
                        state_d = StWrite;
                    end
                end
            end
            StWrite: begin
                // Address and data stay registered until memory takes the word.
                if (mem_ready) begin
                    count_d = count_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                    csum_d  = csum_q ^ wdata_q;
                    state_d = StRun;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            addr_q  <= BaseAddr;
            wdata_q <= '0;
            count_q <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            csum_q  <= csum_d;
        end
    end

    // Outputs decode directly from the registered state.
    always_comb begin
        s_ready    = (state_q == StRun);
        mem_we     = (state_q == StWrite);
        busy       = (state_q == StRun) || (state_q == StWrite);
        done       = (state_q == StDone);
        error      = (state_q == StErr);
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        word_count = count_q;
        checksum   = csum_q;
    end

endmodule

// File: doc/mips_prog_encoder.md
Name: mips_prog_encoder

Overview:
- Encoder counterpart to the main control decoder: takes decoded instruction descriptors (instruction class plus register/immediate fields) over a valid/ready stream.
- Assembles each descriptor into the 32-bit MIPS word the decoder consumes, using the same seven opcode classes.
- Writes the words sequentially into instruction memory through a backpressured write port.
- Sits between the test/program-generation front end and the instruction RAM. Reports word count and an XOR checksum when the program ends.

Parameters:
- ADDR_W, 8, width of the word address on the memory port.
- BASE_ADDR, 0, first word address written after start.
- DEPTH, 256, maximum number of words per program (capacity check).

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a program load (honoured in IDLE, DONE, ERR only).
- s_valid  in  1  descriptor valid.
- s_ready  out  1  descriptor accepted when s_valid & s_ready.
- s_kind  in  3  0=R-type, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=ANDI, 6=J, 7=END.
- s_rs, s_rt, s_rd  in  5 each  register fields.
- s_funct  in  6  R-type funct.
- s_imm  in  16  I-type immediate/offset, passed verbatim.
- s_target  in  26  J-type target field.
- mem_we  out  1  write request.
- mem_ready  in  1  memory accepts the write when mem_we & mem_ready.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  high in RUN or WRITE.
- done  out  1  high in DONE.
- error  out  1  high in ERR (capacity overflow).
- word_count  out  ADDR_W+1  words written in the current program.
- checksum  out  32  XOR of all words written in the current program.

Behaviour:
- Reset: clk edge with resetn=0 → IDLE. All outputs 0; mem_addr=BASE_ADDR.
- Encoding, with shamt always 0:
  - R: {6'b000000, rs, rt, rd, 5'b0, funct}.
  - LW, SW, BEQ, ADDI, ANDI: {op, rs, rt, imm}, with op = 100011 / 101011 / 000100 / 001000 / 001100 respectively.
  - J: {000010, target}.
  - Fields not used by a kind are ignored.
- FSM states: IDLE, RUN, WRITE, DONE, ERR.
- IDLE: s_ready=0.
  - On start → RUN; mem_addr=BASE_ADDR, word_count=0, checksum=0.
- RUN: s_ready=1.
  - Accepting END → DONE; no memory write.
  - Accepting any other kind with word_count==DEPTH → ERR; no write.
  - Otherwise, register the encoded word into mem_wdata → WRITE. mem_we is high the cycle after acceptance (latency 1).
- WRITE: s_ready=0; mem_we=1. mem_addr and mem_wdata are held stable until mem_ready.
  - On the mem_ready edge: mem_we drops, word_count+1, mem_addr+1 (wraps modulo 2^ADDR_W), checksum ^= word → RUN.
  - Peak throughput is one word per 2 cycles.
- DONE: done=1. word_count and checksum hold. start restarts as from IDLE.
- ERR: error=1, sticky. Cleared only by start (restart) or reset.
- Ignored events:
  - start in RUN/WRITE is ignored.
  - s_valid while s_ready=0 is not consumed; the source must hold the descriptor.
- Reset mid-WRITE: mem_we is 0 from the next edge and the pending word is dropped.

Test Plan:
- Start, then R-type rs=1 rt=2 rd=3 funct=0x20 → mem_we a cycle later; addr 0, data 0x00221820; word_count=1.
- LW rs=29 rt=8 imm=4, then SW rs=29 rt=8 imm=8 → 0x8FA80004 @0, 0xAFA80008 @1.
- ADDI rt=4 imm=5; ANDI rs=4 rt=5 imm=0xFF; BEQ rs=1 rt=2 imm=0xFFFF; J target=0x10 → 0x20040005, 0x308500FF, 0x1022FFFF, 0x08000010 at consecutive addresses.
- Hold mem_ready=0 for 3 cycles during a write:
  - mem_we, mem_addr and mem_wdata stay stable; s_ready=0; word_count is unchanged until the ready cycle.
  - A descriptor held valid throughout is accepted exactly once.
- After the three words of test 1 and test 2, send END → done=1, word_count=3, checksum=0x00221820^0x8FA80004^0xAFA80008. Then pulse start → counters cleared, addr back to BASE_ADDR.
- With DEPTH=2, send 3 non-END descriptors → 2 writes, then error=1 and no third mem_we. Assert resetn=0 during a WRITE → mem_we=0 and state IDLE on the next edge.
